// File: rtl/topk_pkg.sv
// Shared definitions for the top-k pipeline: default geometry, packer state
// encoding and the helper that builds an all-pad vector.
package topk_pkg;

  localparam int DATA_WIDTH    = 32;
  localparam int LOG_INPUT_NUM = 5;
  localparam int N             = 1 << LOG_INPUT_NUM;

  // Upper bounds that size pad_fill's result; callers slice the low bits they need.
  localparam int MAX_DATA_W  = 64;
  localparam int MAX_LANES   = 64;
  localparam int MAX_VEC_W   = MAX_DATA_W * MAX_LANES;
  localparam int MAX_DATA_AW = $clog2(MAX_DATA_W);
  localparam int MAX_VEC_AW  = $clog2(MAX_VEC_W);

  typedef enum logic {
    S_FILL = 1'b0,
    S_GAP  = 1'b1
  } state_t;

  function automatic logic [MAX_VEC_W-1:0] pad_fill(
    input logic [MAX_DATA_W-1:0] pad,
    input int                    dw,
    input int                    lanes
  );
    logic [MAX_VEC_W-1:0] v;
    v = '0;
    for (int i = 0; i < dw * lanes; i++) begin
      v[MAX_VEC_AW'(i)] = pad[MAX_DATA_AW'(i % dw)];
    end
    return v;
  endfunction

endpackage

// File: rtl/vec_packer_if.sv
// Element stream in, packed vector plus metadata out, for the vector packer.
interface vec_packer_if #(
  parameter int DATA_WIDTH    = topk_pkg::DATA_WIDTH,
  parameter int LOG_INPUT_NUM = topk_pkg::LOG_INPUT_NUM,
  parameter int FRAME_ID_W    = 8
);

  localparam int N = 1 << LOG_INPUT_NUM;

  logic                    i_valid;
  logic [DATA_WIDTH-1:0]   i_data;
  logic                    i_last;
  logic                    o_in_ready;
  logic                    o_valid;
  logic [DATA_WIDTH*N-1:0] o_data;
  logic [LOG_INPUT_NUM:0]  o_cnt;
  logic                    o_last;
  logic [FRAME_ID_W-1:0]   o_frame_id;
  logic                    o_err;

  modport master (
    output i_valid, i_data, i_last,
    input  o_in_ready, o_valid, o_data, o_cnt, o_last, o_frame_id, o_err
  );

  modport slave (
    input  i_valid, i_data, i_last,
    output o_in_ready, o_valid, o_data, o_cnt, o_last, o_frame_id, o_err
  );

endinterface

// File: rtl/vec_packer.sv
// Packs a serial element stream into N-lane vectors, padding the tail vector of
// each frame and tagging every vector with its element count and frame id.
module vec_packer #(
  parameter int                    DATA_WIDTH    = topk_pkg::DATA_WIDTH,
  parameter int                    LOG_INPUT_NUM = topk_pkg::LOG_INPUT_NUM,
  parameter logic [DATA_WIDTH-1:0] PAD_VALUE     = '0,
  parameter int                    FRAME_ID_W    = 8
) (
  input  logic         clk,
  input  logic         rst,
  vec_packer_if.slave  bus
);

  import topk_pkg::*;

  localparam int N     = 1 << LOG_INPUT_NUM;
  localparam int VEC_W = DATA_WIDTH * N;

  localparam logic [MAX_VEC_W-1:0] PAD_FULL = pad_fill(MAX_DATA_W'(PAD_VALUE), DATA_WIDTH, N);
  localparam logic [VEC_W-1:0]     PAD_VEC  = PAD_FULL[VEC_W-1:0];

  localparam logic [LOG_INPUT_NUM-1:0] PTR_TOP = LOG_INPUT_NUM'(N - 1);
  localparam logic [LOG_INPUT_NUM-1:0] PTR_ONE = LOG_INPUT_NUM'(1);
  localparam logic [LOG_INPUT_NUM:0]   CNT_ONE = (LOG_INPUT_NUM + 1)'(1);
  localparam logic [FRAME_ID_W-1:0]    FID_ONE = FRAME_ID_W'(1);

  state_t                   state;
  state_t                   state_next;
  logic [LOG_INPUT_NUM-1:0] lane_ptr;
  logic [VEC_W-1:0]         asm_q;
  logic [VEC_W-1:0]         asm_next;
  logic [VEC_W-1:0]         merged;
  logic                     in_ready;
  logic                     accept;
  logic                     close;

  logic                     valid_q;
  logic [VEC_W-1:0]         data_q;
  logic [LOG_INPUT_NUM:0]   cnt_q;
  logic                     last_q;
  logic [FRAME_ID_W-1:0]    frame_id_q;
  logic                     err_q;

  assign in_ready = (state == S_FILL);
  assign accept   = bus.i_valid & in_ready;
  assign close    = accept & ((lane_ptr == PTR_TOP) | bus.i_last);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_FILL;
    end else begin
      state <= state_next;
    end
  end

  // A frame end costs exactly one refused cycle before filling resumes.
  always_comb begin
    state_next = state;
    case (state)
      S_FILL:  if (accept && bus.i_last) state_next = S_GAP;
      S_GAP:   state_next = S_FILL;
      default: state_next = S_FILL;
    endcase
  end

  // Per lane: the accepted element writes its lane; on close the emitted vector
  // keeps lanes below the pointer, takes the new element and pads the rest.
  for (genvar k = 0; k < N; k++) begin : g_lane
    localparam logic [LOG_INPUT_NUM-1:0] K = LOG_INPUT_NUM'(k);
    logic                  wr;
    logic [DATA_WIDTH-1:0] held;

    assign wr   = accept && (lane_ptr == K);
    assign held = asm_q[k*DATA_WIDTH +: DATA_WIDTH];

    assign merged[k*DATA_WIDTH +: DATA_WIDTH] =
      wr ? bus.i_data : ((K < lane_ptr) ? held : PAD_VALUE);

    assign asm_next[k*DATA_WIDTH +: DATA_WIDTH] =
      close ? PAD_VALUE : (wr ? bus.i_data : held);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lane_ptr   <= '0;
      asm_q      <= PAD_VEC;
      valid_q    <= 1'b0;
      data_q     <= PAD_VEC;
      cnt_q      <= '0;
      last_q     <= 1'b0;
      frame_id_q <= '0;
      err_q      <= 1'b0;
    end else begin
      asm_q   <= asm_next;
      valid_q <= close;
      if (close) begin
        data_q   <= merged;
        cnt_q    <= {1'b0, lane_ptr} + CNT_ONE;
        last_q   <= bus.i_last;
        lane_ptr <= '0;
      end else if (accept) begin
        lane_ptr <= lane_ptr + PTR_ONE;
      end
      // The id advances once the frame-closing vector has been presented.
      if (valid_q && last_q) begin
        frame_id_q <= frame_id_q + FID_ONE;
      end
      if (bus.i_valid && !in_ready) begin
        err_q <= 1'b1;
      end
    end
  end

  assign bus.o_in_ready = in_ready;
  assign bus.o_valid    = valid_q;
  assign bus.o_data     = data_q;
  assign bus.o_cnt      = cnt_q;
  assign bus.o_last     = last_q;
  assign bus.o_frame_id = frame_id_q;
  assign bus.o_err      = err_q;

endmodule

// File: tb/tb_vec_packer.sv
// Directed bench for vec_packer with N=4 lanes and a 2-bit frame id.
module tb_vec_packer;

  localparam int DW   = 32;
  localparam int LIN  = 2;
  localparam int FIDW = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  vec_packer_if #(.DATA_WIDTH(DW), .LOG_INPUT_NUM(LIN), .FRAME_ID_W(FIDW)) bus ();

  vec_packer #(
    .DATA_WIDTH(DW),
    .LOG_INPUT_NUM(LIN),
    .PAD_VALUE(32'h0),
    .FRAME_ID_W(FIDW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  function automatic logic [127:0] lanes4(input logic [31:0] l0, l1, l2, l3);
    return {l3, l2, l1, l0};
  endfunction

  task automatic check_output(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_vec(input string tag, input logic [127:0] data, input int cnt,
                           input logic last, input int fid);
    check_output({tag, "_valid"}, 128'(bus.o_valid), 128'(1));
    check_output({tag, "_data"}, bus.o_data, data);
    check_output({tag, "_cnt"}, 128'(bus.o_cnt), 128'(cnt));
    check_output({tag, "_last"}, 128'(bus.o_last), 128'(last));
    check_output({tag, "_fid"}, 128'(bus.o_frame_id), 128'(fid));
  endtask

  // Drive one cycle of input, then look at the outputs just after the edge.
  task automatic apply_stimulus(input logic v, input logic [31:0] d, input logic l);
    bus.i_valid = v;
    bus.i_data  = d;
    bus.i_last  = l;
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.i_valid = 1'b0;
    bus.i_data  = '0;
    bus.i_last  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_output("rst_valid", 128'(bus.o_valid), 128'(0));
    check_output("rst_data", bus.o_data, 128'(0));
    check_output("rst_cnt", 128'(bus.o_cnt), 128'(0));
    check_output("rst_last", 128'(bus.o_last), 128'(0));
    check_output("rst_fid", 128'(bus.o_frame_id), 128'(0));
    check_output("rst_err", 128'(bus.o_err), 128'(0));
    check_output("rst_ready", 128'(bus.o_in_ready), 128'(1));
    rst = 1'b1;
    apply_stimulus(1'b0, 32'd0, 1'b0);

    $display("[TB] full vector without last");
    apply_stimulus(1'b1, 32'd1, 1'b0);
    check_output("t1_v1", 128'(bus.o_valid), 128'(0));
    apply_stimulus(1'b1, 32'd2, 1'b0);
    check_output("t1_v2", 128'(bus.o_valid), 128'(0));
    apply_stimulus(1'b1, 32'd3, 1'b0);
    check_output("t1_v3", 128'(bus.o_valid), 128'(0));
    apply_stimulus(1'b1, 32'd4, 1'b0);
    check_vec("t1", lanes4(1, 2, 3, 4), 4, 1'b0, 0);
    apply_stimulus(1'b0, 32'd0, 1'b0);
    check_output("t1_pulse", 128'(bus.o_valid), 128'(0));
    check_output("t1_hold", bus.o_data, lanes4(1, 2, 3, 4));

    $display("[TB] short frame with padding and frame id wrap");
    apply_stimulus(1'b1, 32'd5, 1'b0);
    apply_stimulus(1'b1, 32'd6, 1'b1);
    check_vec("t2", lanes4(5, 6, 0, 0), 2, 1'b1, 0);
    check_output("t2_gap_ready", 128'(bus.o_in_ready), 128'(0));
    apply_stimulus(1'b0, 32'd0, 1'b0);
    check_output("t2_ready_back", 128'(bus.o_in_ready), 128'(1));
    check_output("t2_fid_inc", 128'(bus.o_frame_id), 128'(1));
    for (int f = 1; f < 4; f++) begin
      apply_stimulus(1'b1, 32'(20 + f), 1'b1);
      check_vec("t2_frame", lanes4(32'(20 + f), 0, 0, 0), 1, 1'b1, f);
      apply_stimulus(1'b0, 32'd0, 1'b0);
    end
    check_output("t2_wrap", 128'(bus.o_frame_id), 128'(0));

    $display("[TB] last on the final lane");
    apply_stimulus(1'b1, 32'd7, 1'b0);
    apply_stimulus(1'b1, 32'd8, 1'b0);
    apply_stimulus(1'b1, 32'd9, 1'b0);
    apply_stimulus(1'b1, 32'd10, 1'b1);
    check_vec("t3", lanes4(7, 8, 9, 10), 4, 1'b1, 0);
    apply_stimulus(1'b0, 32'd0, 1'b0);

    $display("[TB] back-to-back streaming");
    for (int i = 0; i < 8; i++) begin
      apply_stimulus(1'b1, 32'(11 + i), 1'b0);
      check_output("t4_ready", 128'(bus.o_in_ready), 128'(1));
      check_output("t4_valid", 128'(bus.o_valid), 128'((i % 4) == 3));
    end
    check_vec("t4", lanes4(15, 16, 17, 18), 4, 1'b0, 1);

    $display("[TB] element during the gap cycle");
    apply_stimulus(1'b1, 32'd19, 1'b1);
    check_vec("t5_close", lanes4(19, 0, 0, 0), 1, 1'b1, 1);
    apply_stimulus(1'b1, 32'd99, 1'b0);
    check_output("t5_err", 128'(bus.o_err), 128'(1));
    check_output("t5_no_valid", 128'(bus.o_valid), 128'(0));
    apply_stimulus(1'b1, 32'd20, 1'b0);
    apply_stimulus(1'b1, 32'd21, 1'b0);
    apply_stimulus(1'b1, 32'd22, 1'b0);
    apply_stimulus(1'b1, 32'd23, 1'b0);
    check_vec("t5", lanes4(20, 21, 22, 23), 4, 1'b0, 2);
    check_output("t5_err_sticky", 128'(bus.o_err), 128'(1));

    $display("[TB] reset mid-vector");
    apply_stimulus(1'b1, 32'd30, 1'b0);
    apply_stimulus(1'b1, 32'd31, 1'b0);
    bus.i_valid = 1'b0;
    rst = 1'b0;
    #1;
    check_output("t6_valid", 128'(bus.o_valid), 128'(0));
    check_output("t6_data", bus.o_data, 128'(0));
    check_output("t6_cnt", 128'(bus.o_cnt), 128'(0));
    check_output("t6_fid", 128'(bus.o_frame_id), 128'(0));
    check_output("t6_err", 128'(bus.o_err), 128'(0));
    @(posedge clk);
    #1;
    check_output("t6_hold_valid", 128'(bus.o_valid), 128'(0));
    rst = 1'b1;
    apply_stimulus(1'b1, 32'd40, 1'b0);
    apply_stimulus(1'b1, 32'd41, 1'b0);
    apply_stimulus(1'b1, 32'd42, 1'b0);
    check_output("t6_partial", 128'(bus.o_valid), 128'(0));
    apply_stimulus(1'b1, 32'd43, 1'b0);
    check_vec("t6", lanes4(40, 41, 42, 43), 4, 1'b0, 0);
    check_output("t6_err_clear", 128'(bus.o_err), 128'(0));
    apply_stimulus(1'b0, 32'd0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
